// File: rtl/core_msg_receiver_pkg.sv
// Shared definitions for the per-core receive end of the scheduler message bus.
package core_msg_receiver_pkg;

    localparam int SCHED_MSG_BUS_WIDTH = 16;
    localparam int CRX_R0_WORDS        = 13;

    typedef enum logic [1:0] {
        CRX_IDLE = 2'd0,
        CRX_SEL  = 2'd1,
        CRX_LOAD = 2'd2,
        CRX_EXEC = 2'd3
    } crx_state_e;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] pc;
        pc = '0;
        for (int i = 0; i < 32; i++) pc = pc + 6'(v[i]);
        return pc;
    endfunction

endpackage

// File: rtl/core_ibuf.sv
// Instruction buffer: simple dual-port synchronous RAM, one write and one registered read port.
module core_ibuf #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Read-during-write to the same address returns the previous word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_o <= '0;
        else       rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/core_msg_receiver.sv
// Per-core receiver: decodes scheduler loading flags, captures masks/r0, buffers instructions,
// then hands off to execution and reports readiness.
module core_msg_receiver
    import core_msg_receiver_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int BUS_W      = SCHED_MSG_BUS_WIDTH,
    parameter int IBUF_DEPTH = 256,
    parameter int GAP_CYCLES = 4,
    localparam int AW        = $clog2(IBUF_DEPTH),
    localparam int GW        = $clog2(GAP_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] mess_to_core,
    input  logic             core_mask_loading,
    input  logic             r0_mask_loading,
    input  logic             r0_loading,
    input  logic             instr_loading,
    input  logic             exec_done,
    input  logic [AW-1:0]    ibuf_raddr,
    output logic [BUS_W-1:0] ibuf_rdata,
    output logic             core_reading,
    output logic             core_ready,
    output logic             start_exec,
    output logic [BUS_W-1:0] r0_data,
    output logic             r0_valid,
    output logic [AW:0]      instr_count,
    output logic             ibuf_ovf
);

    crx_state_e       state_q, state_d;
    logic             selected_q, selected_d;
    logic             r0_sel_q, r0_sel_d;
    logic [5:0]       rank_q, rank_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [BUS_W-1:0] r0_data_q, r0_data_d;
    logic             r0_valid_q, r0_valid_d;
    logic             reading_q, start_q;
    logic             we;
    logic             my_bit;
    logic [31:0]      lower_bits;

    assign my_bit     = mess_to_core[CORE_ID];
    assign lower_bits = 32'(mess_to_core) & ((32'd1 << CORE_ID) - 32'd1);

    always_comb begin
        state_d    = state_q;
        selected_d = selected_q;
        r0_sel_d   = r0_sel_q;
        rank_d     = rank_q;
        rcnt_d     = rcnt_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        r0_data_d  = r0_data_q;
        r0_valid_d = r0_valid_q;
        we         = 1'b0;
        if (state_q == CRX_EXEC) begin
            // Loading flags are ignored here; a coincident mask is deliberately dropped.
            if (exec_done) state_d = CRX_IDLE;
        end else begin
            if (core_mask_loading) begin
                selected_d = my_bit;
                r0_valid_d = 1'b0;
                r0_data_d  = '0;
                cnt_d      = '0;
                rcnt_d     = '0;
                gap_d      = '0;
                if (state_q == CRX_LOAD) state_d = CRX_EXEC;
                else                     state_d = my_bit ? CRX_SEL : CRX_IDLE;
            end else if (r0_mask_loading) begin
                if (state_q == CRX_SEL) begin
                    r0_sel_d = my_bit;
                    rank_d   = popcount32(lower_bits);
                end
            end else if (r0_loading) begin
                if (state_q == CRX_SEL) begin
                    if (rcnt_q != 4'(CRX_R0_WORDS)) rcnt_d = rcnt_q + 4'd1;
                    if (r0_sel_q && (rank_q < 6'(CRX_R0_WORDS)) && ({2'b00, rcnt_q} == rank_q)) begin
                        r0_data_d  = mess_to_core;
                        r0_valid_d = 1'b1;
                    end
                end
            end else if (instr_loading) begin
                if (state_q == CRX_SEL || state_q == CRX_LOAD) begin
                    if (cnt_q != (AW+1)'(IBUF_DEPTH)) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = CRX_LOAD;
                end
            end
            // Idle beats during LOAD count toward the end-of-task gap.
            if (state_q == CRX_LOAD && !instr_loading && !core_mask_loading) begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = CRX_EXEC;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CRX_IDLE;
            selected_q <= 1'b0;
            r0_sel_q   <= 1'b0;
            rank_q     <= '0;
            rcnt_q     <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            r0_data_q  <= '0;
            r0_valid_q <= 1'b0;
            reading_q  <= 1'b1;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            selected_q <= selected_d;
            r0_sel_q   <= r0_sel_d;
            rank_q     <= rank_d;
            rcnt_q     <= rcnt_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            r0_data_q  <= r0_data_d;
            r0_valid_q <= r0_valid_d;
            reading_q  <= (state_d != CRX_EXEC);
            start_q    <= (state_d == CRX_EXEC) && (state_q != CRX_EXEC);
        end
    end

    core_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .W     (BUS_W)
    ) u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (mess_to_core),
        .raddr_i (ibuf_raddr),
        .rdata_o (ibuf_rdata)
    );

    assign core_reading = reading_q;
    assign core_ready   = reading_q;
    assign start_exec   = start_q;
    assign r0_data      = r0_data_q;
    assign r0_valid     = r0_valid_q;
    assign instr_count  = cnt_q;
    assign ibuf_ovf     = ovf_q;

endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed bench for core_msg_receiver (CORE_ID=3): vector table plus multi-cycle sequences.
module tb_core_msg_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mess;
    logic        cm, rm, r0l, il, ed;
    logic [7:0]  raddr;
    logic [15:0] rdata;
    logic        reading, ready, start, r0v;
    logic [15:0] r0d;
    logic [8:0]  cnt;
    logic        ovf;

    int tests = 0;
    int errs  = 0;

    localparam logic [3:0] F_NONE = 4'b0000, F_M = 4'b1000, F_RM = 4'b0100,
                           F_R = 4'b0010, F_I = 4'b0001;

    typedef struct {
        logic [3:0]  flg;
        logic        ed;
        logic [15:0] mess;
        logic        rd;
        logic        rdy;
        logic        st;
        logic        rv;
        logic [15:0] rdat;
        logic [8:0]  cnt;
    } vec_t;

    vec_t tv[$];

    core_msg_receiver #(.CORE_ID(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .mess_to_core      (mess),
        .core_mask_loading (cm),
        .r0_mask_loading   (rm),
        .r0_loading        (r0l),
        .instr_loading     (il),
        .exec_done         (ed),
        .ibuf_raddr        (raddr),
        .ibuf_rdata        (rdata),
        .core_reading      (reading),
        .core_ready        (ready),
        .start_exec        (start),
        .r0_data           (r0d),
        .r0_valid          (r0v),
        .instr_count       (cnt),
        .ibuf_ovf          (ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic [3:0] f, input logic e, input logic [15:0] m,
                               input logic rd, input logic rdy, input logic st, input logic rv,
                               input logic [15:0] rdat, input logic [8:0] c);
        vec_t v;
        v.flg = f; v.ed = e; v.mess = m; v.rd = rd; v.rdy = rdy; v.st = st;
        v.rv = rv; v.rdat = rdat; v.cnt = c;
        return v;
    endfunction

    task automatic step(input logic [3:0] f, input logic e, input logic [15:0] m);
        {cm, rm, r0l, il} = f;
        ed   = e;
        mess = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; mess = '0; cm = 0; rm = 0; r0l = 0; il = 0; ed = 0; raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {reading, ready, start, r0v, r0d, cnt, ovf, rdata},
            {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 1'b0, 16'h0});
        reset = 1'b0;

        // Selected task with rank-2 r0 capture and gapped instruction stream.
        tv.push_back(V(F_M,   0, 16'h0009, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_RM,  0, 16'h000B, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_R,   0, 16'h00A0, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_R,   0, 16'h00A1, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_R,   0, 16'h00A2, 1, 1, 0, 1, 16'hA2, 9'd0));
        tv.push_back(V(F_R,   0, 16'h00A3, 1, 1, 0, 1, 16'hA2, 9'd0));
        tv.push_back(V(F_I,   0, 16'h1000, 1, 1, 0, 1, 16'hA2, 9'd1));
        tv.push_back(V(F_I,   0, 16'h1001, 1, 1, 0, 1, 16'hA2, 9'd2));
        tv.push_back(V(F_NONE,0, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd2));
        tv.push_back(V(F_NONE,0, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd2));
        tv.push_back(V(F_I,   0, 16'h1002, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,0, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,0, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,0, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,0, 16'h0000, 0, 0, 1, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,0, 16'h0000, 0, 0, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_I,   0, 16'hBEEF, 0, 0, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_M,   0, 16'h0008, 0, 0, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,1, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_R,   0, 16'h0055, 1, 1, 0, 1, 16'hA2, 9'd3));
        tv.push_back(V(F_NONE,1, 16'h0000, 1, 1, 0, 1, 16'hA2, 9'd3));
        // Not selected: clears, then all r0/instr traffic is ignored.
        tv.push_back(V(F_M,   0, 16'h0001, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_RM,  0, 16'hFFFF, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_R,   0, 16'h0055, 1, 1, 0, 0, 16'h00, 9'd0));
        tv.push_back(V(F_I,   0, 16'h0077, 1, 1, 0, 0, 16'h00, 9'd0));
        for (int i = 0; i < 5; i++)
            tv.push_back(V(F_NONE, 0, 16'h0000, 1, 1, 0, 0, 16'h00, 9'd0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].flg, tv[i].ed, tv[i].mess);
            chk($sformatf("vec%0d", i), {7'd0, reading, ready, start, r0v, r0d, cnt},
                {7'd0, tv[i].rd, tv[i].rdy, tv[i].st, tv[i].rv, tv[i].rdat, tv[i].cnt});
        end

        // 16 words, 4-cycle gap to EXEC, readback, exec_done.
        step(F_M, 0, 16'h0008);
        for (int i = 0; i < 16; i++) step(F_I, 0, 16'h2000 + 16'(i));
        chk("a_cnt16", 32'(cnt), 32'd16);
        for (int i = 0; i < 3; i++) step(F_NONE, 0, 16'h0);
        chk("a_no_early_exec", {30'd0, start, reading}, {30'd0, 1'b0, 1'b1});
        step(F_NONE, 0, 16'h0);
        chk("a_exec_entry", {29'd0, start, ready, reading}, {29'd0, 1'b1, 1'b0, 1'b0});
        raddr = 8'd5;
        step(F_NONE, 0, 16'h0);
        chk("a_rdata5", 32'(rdata), 32'h2005);
        chk("a_start_pulse", {31'd0, start}, 32'd0);
        step(F_NONE, 1, 16'h0);
        chk("a_done_ready", {30'd0, ready, reading}, {30'd0, 1'b1, 1'b1});

        // Overflow: 300 words into a 256-word buffer.
        step(F_M, 0, 16'h0008);
        for (int i = 0; i < 256; i++) step(F_I, 0, 16'(i) ^ 16'h5A00);
        chk("b_full_no_ovf", {22'd0, ovf, cnt}, {22'd0, 1'b0, 9'd256});
        for (int i = 256; i < 300; i++) step(F_I, 0, 16'(i) ^ 16'h5A00);
        chk("b_ovf", {21'd0, reading, ovf, cnt}, {21'd0, 1'b1, 1'b1, 9'd256});
        raddr = 8'd255;
        step(F_NONE, 0, 16'h0);
        chk("b_rdata255", 32'(rdata), 32'h5AFF);
        for (int i = 0; i < 3; i++) step(F_NONE, 0, 16'h0);
        chk("b_exec", {30'd0, start, reading}, {30'd0, 1'b1, 1'b0});

        // exec_done wins over a coincident mask: IDLE, nothing cleared.
        step(F_M, 1, 16'h0008);
        chk("c_done_mask", {21'd0, reading, ovf, cnt}, {21'd0, 1'b1, 1'b1, 9'd256});
        step(F_I, 0, 16'h1234);
        chk("c_idle_ignores", 32'(cnt), 32'd256);

        // Reset mid-LOAD.
        step(F_M, 0, 16'h0008);
        chk("d_ovf_sticky", {22'd0, ovf, cnt}, {22'd0, 1'b1, 9'd0});
        for (int i = 0; i < 5; i++) step(F_I, 0, 16'h3000 + 16'(i));
        chk("d_cnt5", {30'd0, reading, 1'b0}, {30'd0, 1'b1, 1'b0});
        chk("d_cnt5_val", 32'(cnt), 32'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("d_reset", {19'd0, reading, ready, start, ovf, cnt},
            {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(F_NONE, 0, 16'h0);
        chk("d_idle_after_reset", {30'd0, reading, start}, {30'd0, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
